data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Two-requester arbiter sharing the single-port 8-bit data memory (async read, write on posedge).
//   Port 0 = CPU datapath load/store, port 1 = DMA/loader. Round-robin ownership with bounded
//   bursts. Drives the memory's write-enable/address/write-data; returns registered read data per port.
// PARAMETERS
//   DATA_W     8   data width, matches data memory word
//   ADDR_W     8   address width (256 words)
//   MAX_BURST  4   max consecutive beats one owner keeps while the other requests (>=1)
// PORTS
//   clock        in   1       system clock, all state on posedge
//   reset_n      in   1       synchronous reset, active low
//   req0/req1    in   1       port request; hold with we/addr/wdata stable until gntN=1
//   we0/we1      in   1       1 = write beat, 0 = read beat
//   addr0/addr1  in   ADDR_W  beat address
//   wdata0/1     in   DATA_W  write data
//   gnt0/gnt1    out  1       beat accepted this cycle (combinational)
//   rdata0/1     out  DATA_W  read data, registered
//   rvalid0/1    out  1       rdataN valid, 1-cycle pulse
//   mem_write    out  1       to memory memWrite
//   mem_addr     out  ADDR_W  to memory address
//   mem_wdata    out  DATA_W  to memory data
//   mem_rdata    in   DATA_W  from memory out (async read of mem_addr)
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=IDLE, prio=port0, beat_cnt=0, rdata0/1=0, rvalid0/1=0.
//     gnt0/1, mem_write=0 and mem_addr/mem_wdata=0 while in reset/IDLE. In-flight beat is dropped.
//   States: IDLE, OWN0, OWN1 (registered). gntN = (state==OWNN) & reqN.
//   Memory mux: OWNN -> mem_addr=addrN, mem_wdata=wdataN, mem_write=gntN & weN; IDLE -> zeros.
//   Write commits at the posedge ending the gnt cycle. Read: mem_rdata captured at end of gnt cycle
//     into rdataN, rvalidN=1 next cycle only; rdataN holds until next read of that port.
//   IDLE: no req -> IDLE. One req -> OWN of that port. Both -> OWN of prio port.
//     Latency req (from IDLE) -> gnt = 1 cycle; read req -> rvalid = 2 cycles.
//   OWNN, end of cycle (other = M):
//     gntN & beat_cnt==MAX_BURST-1 & reqM -> OWNM, beat_cnt=0, prio=M.
//     gntN otherwise -> stay, beat_cnt += 1 saturating at MAX_BURST-1 (no wrap).
//     !reqN & reqM -> OWNM, beat_cnt=0, prio=M (one dead cycle, no gnt).
//     !reqN & !reqM -> IDLE, beat_cnt=0, prio=M.
//   Sole requester keeps ownership indefinitely (counter saturates, no forced idle).
//   Simultaneous: owner's req drop and other's req rise in same cycle -> switch to OWNM.
//   Never both gnt high; mem_write never high without a gnt.
//   MAX_BURST=1 -> strict alternation when both request. beat_cnt width = clog2(MAX_BURST)+1.
// TESTING
//   1 Reset: reset_n=0 two cycles with req0=req1=1 -> all outputs 0; release -> gnt0 next cycle.
//   2 Single read: req0, we0=0, addr0=100 (memory holds 10) -> gnt0 cycle 1, rvalid0=1, rdata0=10 cycle 2.
//   3 Write-then-read port1: write 8'hA5 to addr 50, then read 50 -> mem_write 1 cycle, rdata1=8'hA5.
//   4 Contention, MAX_BURST=4, req0/req1 held: grants 0,0,0,0,1,1,1,1,0... no gap, never both high.
//   5 Owner release: OWN0, req0 drops as req1 rises -> one dead cycle, then gnt1; prio=1 after.
//   6 Reset mid-burst: reset_n=0 on 2nd beat of port1 write -> no mem_write that cycle, IDLE, rvalid=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : Requester and memory-side bundle for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              req0,  req1;
   logic              we0,   we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0,  gnt1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              rvalid0, rvalid1;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
             mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
             mem_write, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Round-robin, burst-bounded arbiter for a single-port data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   data_mem_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic              prio_q,   prio_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;

   logic              gnt0, gnt1;
   logic              own_is1, own_gnt, oth_req;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

   // Grants are gated by reset so an in-flight beat never reaches memory.
   always_comb begin
      gnt0      = reset_n && (state_q == OWN0) && bus.req0;
      gnt1      = reset_n && (state_q == OWN1) && bus.req1;
      addr_mux  = '0;
      wdata_mux = '0;
      if (reset_n && state_q == OWN0) begin
         addr_mux  = bus.addr0;
         wdata_mux = bus.wdata0;
      end else if (reset_n && state_q == OWN1) begin
         addr_mux  = bus.addr1;
         wdata_mux = bus.wdata1;
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.mem_write = (gnt0 && bus.we0) || (gnt1 && bus.we1);
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      cnt_d     = cnt_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      own_is1   = (state_q == OWN1);
      own_gnt   = own_is1 ? gnt1 : gnt0;
      oth_req   = own_is1 ? bus.req0 : bus.req1;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.req0 && bus.req1) begin
               state_d = prio_q ? OWN1 : OWN0;
            end else if (bus.req0) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (own_gnt) begin
               if (cnt_q == LAST_BEAT && oth_req) begin
                  state_d = own_is1 ? OWN0 : OWN1;
                  cnt_d   = '0;
                  prio_d  = ~own_is1;
               end else if (cnt_q != LAST_BEAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (oth_req) begin
               state_d = own_is1 ? OWN0 : OWN1;
               cnt_d   = '0;
               prio_d  = ~own_is1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               prio_d  = ~own_is1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (gnt0 && !bus.we0) begin
         rdata0_d  = bus.mem_rdata;
         rvalid0_d = 1'b1;
      end
      if (gnt1 && !bus.we1) begin
         rdata1_d  = bus.mem_rdata;
         rvalid1_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         prio_q    <= 1'b0;
         cnt_q     <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         cnt_q     <= cnt_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed self-checking bench for data_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_pass;
   logic [7:0] mem_model [0:255];

   data_mem_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   data_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_BURST(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port memory: async read, write on posedge.
   assign bus.mem_rdata = mem_model[bus.mem_addr];
   always @(posedge clock) begin
      if (bus.mem_write) mem_model[bus.mem_addr] = bus.mem_wdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = 8'd0; bus.addr1 = 8'd0; bus.wdata0 = 8'd0; bus.wdata1 = 8'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.mem_write, bus.rvalid0, bus.rvalid1} !== 5'b0) $display("FAIL reset_ctrl: got %b required 00000", {bus.gnt0, bus.gnt1, bus.mem_write, bus.rvalid0, bus.rvalid1});
      else n_pass++;
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== 32'h0) $display("FAIL reset_data: got %h required 00000000", {bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1});
      else n_pass++;
      cyc();
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL reset_release_idle: got %b required 00", {bus.gnt1, bus.gnt0});
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL reset_first_gnt: got %b required 01", {bus.gnt1, bus.gnt0});
      else n_pass++;
   endtask

   task automatic test_single_read();
      do_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd100;
      @(negedge clock);
      n_checks++;
      if (bus.gnt0 !== 1'b0) $display("FAIL read_idle_gnt: got %b required 0", bus.gnt0);
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt0, bus.mem_addr, bus.mem_write} !== {1'b1, 8'd100, 1'b0}) $display("FAIL read_gnt: got %b/%0d/%b required 1/100/0", bus.gnt0, bus.mem_addr, bus.mem_write);
      else n_pass++;
      cyc();
      bus.req0 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'd10}) $display("FAIL read_data: got %b/%0d required 1/10", bus.rvalid0, bus.rdata0);
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b0, 8'd10}) $display("FAIL read_hold: got %b/%0d required 0/10", bus.rvalid0, bus.rdata0);
      else n_pass++;
   endtask

   task automatic test_write_read_port1();
      do_reset();
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd50; bus.wdata1 = 8'hA5;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.mem_write} !== 2'b00) $display("FAIL wr_idle: got %b required 00", {bus.gnt1, bus.mem_write});
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {2'b11, 8'd50, 8'hA5}) $display("FAIL wr_beat: got %b%b/%0d/%h required 11/50/a5", bus.gnt1, bus.mem_write, bus.mem_addr, bus.mem_wdata);
      else n_pass++;
      cyc();
      bus.we1 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.mem_write} !== 2'b10) $display("FAIL rd_after_wr: got %b required 10", {bus.gnt1, bus.mem_write});
      else n_pass++;
      cyc();
      bus.req1 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.rvalid1, bus.rdata1, bus.rvalid0} !== {1'b1, 8'hA5, 1'b0}) $display("FAIL rd1_data: got %b/%h/%b required 1/a5/0", bus.rvalid1, bus.rdata1, bus.rvalid0);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic [1:0] exp;
      do_reset();
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 8'd1; bus.addr1 = 8'd2;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL cont_idle: got %b required 00", {bus.gnt1, bus.gnt0});
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         cyc();
         @(negedge clock);
         exp = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
         n_checks++;
         if ({bus.gnt1, bus.gnt0} !== exp) $display("FAIL cont_beat%0d: got %b required %b", i, {bus.gnt1, bus.gnt0}, exp);
         else n_pass++;
      end
   endtask

   task automatic test_owner_release();
      do_reset();
      bus.req0 = 1'b1;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rel_own0: got %b required 01", {bus.gnt1, bus.gnt0});
      else n_pass++;
      cyc();
      bus.req0 = 1'b0; bus.req1 = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL rel_dead: got %b required 00", {bus.gnt1, bus.gnt0});
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL rel_gnt1: got %b required 10", {bus.gnt1, bus.gnt0});
      else n_pass++;
   endtask

   task automatic test_prio_after_idle();
      do_reset();
      bus.req0 = 1'b1;
      cyc();
      cyc();
      bus.req0 = 1'b0;
      cyc();
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL prio_rr: got %b required 10", {bus.gnt1, bus.gnt0});
      else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      bus.req0 = 1'b1;
      repeat (7) cyc();
      bus.req1 = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL sat_last_beat: got %b required 01", {bus.gnt1, bus.gnt0});
      else n_pass++;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL sat_switch: got %b required 10", {bus.gnt1, bus.gnt0});
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd60; bus.wdata1 = 8'h5A;
      cyc();
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.mem_write} !== 2'b11) $display("FAIL rmb_first: got %b required 11", {bus.gnt1, bus.mem_write});
      else n_pass++;
      cyc();
      bus.addr1 = 8'd61; bus.wdata1 = 8'h77; reset_n = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.mem_write, bus.mem_addr} !== 10'b0) $display("FAIL rmb_blocked: got %b%b/%0d required 00/0", bus.gnt1, bus.mem_write, bus.mem_addr);
      else n_pass++;
      cyc();
      reset_n = 1'b1; bus.req1 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.gnt1, bus.rvalid1, bus.rvalid0} !== 3'b000) $display("FAIL rmb_idle: got %b required 000", {bus.gnt1, bus.rvalid1, bus.rvalid0});
      else n_pass++;
      n_checks++;
      if ({mem_model[60], mem_model[61]} !== {8'h5A, 8'h00}) $display("FAIL rmb_mem: got %h/%h required 5a/00", mem_model[60], mem_model[61]);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int a = 0; a < 256; a++) mem_model[a] = 8'h00;
      mem_model[100] = 8'd10;
      test_reset();
      test_single_read();
      test_write_read_port1();
      test_contention();
      test_owner_release();
      test_prio_after_idle();
      test_saturation();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
